// File: rtl/tdm_pkg.sv
// Shared TDM definitions: framing state encoding and slot indices.
// Used by both the receive-side demux and the transmit-side mux.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    localparam int unsigned NUM_SLOTS = 4;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Frame tracker: 2-bit wrapping slot counter plus HUNT/LOCKED framing state.
// clear returns to HUNT at slot 0; load1 locks at slot 1; advance steps the slot.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load1,
    input  logic       advance,
    output logic [1:0] slot,
    output tdm_state_t state
);

    tdm_state_t state_nx;
    logic [1:0] slot_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            slot  <= SLOT_A;
        end else begin
            state <= state_nx;
            slot  <= slot_nx;
        end
    end

    always_comb begin
        state_nx = state;
        slot_nx  = slot;
        if (clear) begin
            state_nx = HUNT;
            slot_nx  = SLOT_A;
        end else if (load1) begin
            state_nx = LOCKED;
            slot_nx  = SLOT_B;
        end else if (advance) begin
            // slot 3 -> 0 comes from the natural 2-bit wrap
            slot_nx  = slot + 2'd1;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: steers each slot word into its channel register,
// with one-hot channel strobes, frame-done and framing-error pulses.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         frame_sync,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic [W-1:0] C,
    output logic [W-1:0] D,
    output logic [3:0]   out_valid,
    output logic [1:0]   slot,
    output logic         locked,
    output logic         frame_done,
    output logic         sync_err
);

    tdm_state_t state;
    logic       clear, load1, advance;
    logic       cap, err, done;
    logic [1:0] cap_idx;
    logic [3:0] strobe;

    tdm_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .load1   (load1),
        .advance (advance),
        .slot    (slot),
        .state   (state)
    );

    assign locked = (state == LOCKED);

    always_comb begin
        clear   = 1'b0;
        load1   = 1'b0;
        advance = 1'b0;
        cap     = 1'b0;
        err     = 1'b0;
        done    = 1'b0;
        cap_idx = SLOT_A;
        if (din_valid) begin
            if (frame_sync) begin
                // a sync beat always restarts at A; mid-frame it also flags an error
                cap   = 1'b1;
                load1 = 1'b1;
                err   = (state == LOCKED) && (slot != SLOT_A);
            end else if (state == LOCKED) begin
                if (slot == SLOT_A) begin
                    err   = 1'b1;
                    clear = 1'b1;
                end else begin
                    cap     = 1'b1;
                    cap_idx = slot;
                    advance = 1'b1;
                    done    = (slot == SLOT_D);
                end
            end
        end
    end

    always_comb begin
        strobe = '0;
        if (cap) begin
            unique case (cap_idx)
                SLOT_A: strobe = 4'b0001;
                SLOT_B: strobe = 4'b0010;
                SLOT_C: strobe = 4'b0100;
                SLOT_D: strobe = 4'b1000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A          <= '0;
            B          <= '0;
            C          <= '0;
            D          <= '0;
            out_valid  <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            if (strobe[0]) A <= din;
            if (strobe[1]) B <= din;
            if (strobe[2]) C <= din;
            if (strobe[3]) D <= din;
            out_valid  <= strobe;
            frame_done <= done;
            sync_err   <= err;
        end
    end

endmodule
